// File: rtl/division_func_bw16.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Responds on the ST/RD start-ready handshake; results are held until the next completion.
module division_func_bw16 #(
   parameter int BW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          ST,
   input  logic [BW-1:0] IN0,
   input  logic [BW-1:0] IN1,
   output logic          RD,
   output logic [BW-1:0] RES,
   output logic [BW-1:0] REM,
   output logic          DZ
);

   localparam int CW = $clog2(BW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DIVZ = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          st_old_r;
   logic [BW-1:0] a_r, a_s;
   logic [BW-1:0] b_r, b_s;
   logic [BW-1:0] q_r, q_s;
   logic [BW-1:0] r_r, r_s;
   logic [BW-1:0] res_r, res_s;
   logic [BW-1:0] rem_r, rem_s;
   logic          rd_r, rd_s;
   logic          dz_r, dz_s;

   logic          start_s;
   logic [BW:0]   t_s;
   logic          ge_s;
   logic [BW-1:0] diff_s;
   logic [BW-1:0] r_step_s;
   logic [BW-1:0] q_step_s;

   assign start_s = ST & ~st_old_r;

   // Partial remainder is one bit wider so divisors >= 2^(BW-1) compare correctly;
   // when t_s >= b_r the true difference is below b_r, so the low BW bits are exact.
   assign t_s      = {r_r, q_r[BW-1]};
   assign ge_s     = (t_s >= {1'b0, b_r});
   assign diff_s   = t_s[BW-1:0] - b_r;
   assign r_step_s = ge_s ? diff_s : t_s[BW-1:0];
   assign q_step_s = {q_r[BW-2:0], ge_s};

   // Next-state and datapath update
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      a_s     = a_r;
      b_s     = b_r;
      q_s     = q_r;
      r_s     = r_r;
      res_s   = res_r;
      rem_s   = rem_r;
      rd_s    = rd_r;
      dz_s    = dz_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               a_s  = IN0;
               b_s  = IN1;
               dz_s = 1'b0;
               rd_s = 1'b0;
               if (IN1 == {BW{1'b0}}) begin
                  state_s = DIVZ;
               end else begin
                  q_s     = IN0;
                  r_s     = {BW{1'b0}};
                  cnt_s   = {CW{1'b0}};
                  state_s = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            q_s   = q_step_s;
            r_s   = r_step_s;
            cnt_s = cnt_r + CW'(1);
            if (cnt_r == CW'(BW - 1)) begin
               res_s   = q_step_s;
               rem_s   = r_step_s;
               rd_s    = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = CALC;
            end
         end
         DIVZ: begin
            res_s   = {BW{1'b1}};
            rem_s   = a_r;
            dz_s    = 1'b1;
            rd_s    = 1'b1;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            rd_s    = 1'b1;
         end
      endcase
   end

   // State and result registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r  <= IDLE;
         cnt_r    <= {CW{1'b0}};
         st_old_r <= 1'b0;
         a_r      <= {BW{1'b0}};
         b_r      <= {BW{1'b0}};
         q_r      <= {BW{1'b0}};
         r_r      <= {BW{1'b0}};
         res_r    <= {BW{1'b0}};
         rem_r    <= {BW{1'b0}};
         rd_r     <= 1'b1;
         dz_r     <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         st_old_r <= ST;
         a_r      <= a_s;
         b_r      <= b_s;
         q_r      <= q_s;
         r_r      <= r_s;
         res_r    <= res_s;
         rem_r    <= rem_s;
         rd_r     <= rd_s;
         dz_r     <= dz_s;
      end
   end

   assign RD  = rd_r;
   assign RES = res_r;
   assign REM = rem_r;
   assign DZ  = dz_r;

endmodule

// File: tb/tb_division_func_bw16.sv
// Directed self-checking bench for division_func_bw16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_division_func_bw16;

   logic        CLK;
   logic        RST;
   logic        ST;
   logic [15:0] IN0;
   logic [15:0] IN1;
   logic        RD;
   logic [15:0] RES;
   logic [15:0] REM;
   logic        DZ;

   int tests;
   int fails;

   division_func_bw16 dut (
      .CLK(CLK), .RST(RST), .ST(ST), .IN0(IN0), .IN1(IN1),
      .RD(RD), .RES(RES), .REM(REM), .DZ(DZ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Set operands and pulse ST for one edge; returns at the falling edge after the start edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      @(negedge CLK);
      IN0 = a;
      IN1 = b;
      ST  = 1'b1;
      @(negedge CLK);
      ST  = 1'b0;
   endtask

   // Count falling-edge samples with RD low, starting with the current one (bounded).
   task automatic wait_done(output int low);
      low = 0;
      while (RD === 1'b0 && low < 40) begin
         low++;
         @(negedge CLK);
      end
   endtask

   task automatic test_reset;
      RST = 1'b0;
      ST  = 1'b0;
      IN0 = 16'd0;
      IN1 = 16'd0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      tests++;
      if (RD !== 1'b1 || RES !== 16'd0 || REM !== 16'd0 || DZ !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got RD=%b RES=%h REM=%h DZ=%b, want 1 0000 0000 0", RD, RES, REM, DZ);
      end
   endtask

   task automatic test_basic;
      int low;
      int changed;
      changed = 0;
      start_op(16'd100, 16'd7);
      low = 0;
      while (RD === 1'b0 && low < 40) begin
         low++;
         if (RES !== 16'd0 || REM !== 16'd0) changed++;
         @(negedge CLK);
      end
      tests++;
      if (low != 16) begin
         fails++;
         $display("FAIL basic_busy_len: got %0d cycles low, want 16", low);
      end
      tests++;
      if (changed != 0) begin
         fails++;
         $display("FAIL basic_hold: results changed in %0d busy cycles, want 0", changed);
      end
      tests++;
      if (RES !== 16'd14 || REM !== 16'd2 || DZ !== 1'b0) begin
         fails++;
         $display("FAIL basic_100_7: got RES=%0d REM=%0d DZ=%b, want 14 2 0", RES, REM, DZ);
      end
   endtask

   task automatic test_wide;
      int low;
      start_op(16'hFFFF, 16'h0001);
      wait_done(low);
      tests++;
      if (RES !== 16'hFFFF || REM !== 16'h0000) begin
         fails++;
         $display("FAIL wide_ffff_1: got RES=%h REM=%h, want ffff 0000", RES, REM);
      end
      start_op(16'hFFFF, 16'h8001);
      wait_done(low);
      tests++;
      if (RES !== 16'h0001 || REM !== 16'h7FFE || low != 16) begin
         fails++;
         $display("FAIL wide_ffff_8001: got RES=%h REM=%h low=%0d, want 0001 7ffe 16", RES, REM, low);
      end
   endtask

   task automatic test_small_divz;
      int low;
      start_op(16'd3, 16'd9);
      wait_done(low);
      tests++;
      if (RES !== 16'd0 || REM !== 16'd3) begin
         fails++;
         $display("FAIL small_3_9: got RES=%0d REM=%0d, want 0 3", RES, REM);
      end
      start_op(16'd5, 16'd0);
      wait_done(low);
      tests++;
      if (low != 1) begin
         fails++;
         $display("FAIL divz_busy_len: got %0d cycles low, want 1", low);
      end
      tests++;
      if (RES !== 16'hFFFF || REM !== 16'd5 || DZ !== 1'b1) begin
         fails++;
         $display("FAIL divz_5_0: got RES=%h REM=%0d DZ=%b, want ffff 5 1", RES, REM, DZ);
      end
      start_op(16'd6, 16'd3);
      tests++;
      if (DZ !== 1'b0 || RD !== 1'b0) begin
         fails++;
         $display("FAIL dz_clear: got DZ=%b RD=%b after start, want 0 0", DZ, RD);
      end
      wait_done(low);
      tests++;
      if (RES !== 16'd2 || REM !== 16'd0 || DZ !== 1'b0) begin
         fails++;
         $display("FAIL after_divz_6_3: got RES=%0d REM=%0d DZ=%b, want 2 0 0", RES, REM, DZ);
      end
   endtask

   task automatic test_held_st;
      int  rises;
      logic prev;
      rises = 0;
      @(negedge CLK);
      IN0  = 16'd200;
      IN1  = 16'd10;
      ST   = 1'b1;
      prev = RD;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (i == 3) begin
            IN0 = 16'd999;
            IN1 = 16'd3;
         end
         if (i == 5) ST = 1'b0;
         if (i == 6) ST = 1'b1;
         if (RD === 1'b1 && prev === 1'b0) rises++;
         prev = RD;
      end
      ST = 1'b0;
      tests++;
      if (rises != 1) begin
         fails++;
         $display("FAIL held_st_ops: got %0d RD rises, want 1", rises);
      end
      tests++;
      if (RES !== 16'd20 || REM !== 16'd0 || RD !== 1'b1) begin
         fails++;
         $display("FAIL held_st_result: got RES=%0d REM=%0d RD=%b, want 20 0 1", RES, REM, RD);
      end
   endtask

   task automatic test_reset_mid;
      int low;
      start_op(16'd1000, 16'd7);
      repeat (8) @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      tests++;
      if (RD !== 1'b1 || RES !== 16'd0 || REM !== 16'd0 || DZ !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: got RD=%b RES=%h REM=%h DZ=%b, want 1 0000 0000 0", RD, RES, REM, DZ);
      end
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      start_op(16'd40, 16'd6);
      wait_done(low);
      tests++;
      if (RES !== 16'd6 || REM !== 16'd4 || low != 16) begin
         fails++;
         $display("FAIL after_reset_40_6: got RES=%0d REM=%0d low=%0d, want 6 4 16", RES, REM, low);
      end
   endtask

   task automatic test_random;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] eq;
      logic [15:0] er;
      logic        ez;
      int          rises;
      int          n;
      logic        prev;
      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(1, 65535));
         if (i % 2 == 1) b = (b >> 8) | 16'd1;
         if (i % 7 == 3) b = 16'd0;
         if (b == 16'd0) begin
            eq = 16'hFFFF;
            er = a;
            ez = 1'b1;
         end else begin
            eq = a / b;
            er = a % b;
            ez = 1'b0;
         end
         start_op(a, b);
         rises = 0;
         n     = 0;
         prev  = RD;
         while (n < 40) begin
            @(negedge CLK);
            if (RD === 1'b1 && prev === 1'b0) rises++;
            prev = RD;
            n++;
            if (rises != 0 && n >= 20) break;
         end
         tests++;
         if (RES !== eq || REM !== er || DZ !== ez || rises != 1) begin
            fails++;
            $display("FAIL random_%0d: %h/%h got RES=%h REM=%h DZ=%b rises=%0d, want %h %h %b 1",
                     i, a, b, RES, REM, DZ, rises, eq, er, ez);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_basic();
      test_wide();
      test_small_divz();
      test_held_st();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
